// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer: state encoding and
// the layout of the address byte sent on the wire.
package i2c_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_ADDR,
      S_NBYTES,
      S_WDATA,
      S_RDATA,
      S_GAP,
      S_FAIL
   } state_t;

   // Position of the R/W bit inside the address byte.
   localparam int RNW_BIT = 0;

   // Address byte: 7-bit target address above the R/W bit.
   function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rnw);
      logic [7:0] b;
      b          = {addr, 1'b0};
      b[RNW_BIT] = rnw;
      return b;
   endfunction

endpackage

// File: rtl/i2c_wbuf.sv
// Write-data buffer: a plain register array with one write port used while
// loading user bytes and one asynchronous read port used while replaying
// them to the master. Occupancy is tracked by the sequencer.
module i2c_wbuf #(
   parameter int DATA_DEPTH = 8,
   parameter int WBUF_DEPTH = 8,
   parameter int IDX_W      = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_waddr,
   input  logic [DATA_DEPTH-1:0] i_wdata,
   input  logic [IDX_W-1:0]      i_raddr,
   output logic [DATA_DEPTH-1:0] o_rdata
);

   logic [DATA_DEPTH-1:0] mem [WBUF_DEPTH];

   // Store a byte on each load-port write; contents survive retries.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/i2c_seq_ctrl.sv
// I2C transaction sequencer: takes descriptors and write bytes from the
// user, drives the i2c_master_oe stream ports, forwards read bytes back,
// and replays NAKed transactions from the write buffer with a fixed idle
// gap between attempts.
module i2c_seq_ctrl
   import i2c_pkg::*;
#(
   parameter int DATA_DEPTH  = 8,
   parameter int WBUF_DEPTH  = 8,
   parameter int MAX_RETRIES = 2,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   // descriptor stream
   input  logic                              i_cmd_valid,
   output logic                              o_cmd_ready,
   input  logic [6:0]                        i_cmd_addr,
   input  logic                              i_cmd_rnw,
   input  logic [DATA_DEPTH-1:0]             i_cmd_nbytes,
   // user write bytes
   input  logic [DATA_DEPTH-1:0]             i_wdata_bits,
   input  logic                              i_wdata_valid,
   output logic                              o_wdata_ready,
   // user read bytes
   output logic [DATA_DEPTH-1:0]             o_rdata_bits,
   output logic                              o_rdata_valid,
   input  logic                              i_rdata_ready,
   output logic                              o_rdata_last,
   // status
   output logic                              o_done,
   output logic                              o_err,
   output logic [$clog2(MAX_RETRIES+2)-1:0]  o_attempts,
   // i2c_master_oe side
   output logic                              o_start,
   output logic [DATA_DEPTH-1:0]             o_addr_bits,
   output logic                              o_addr_valid,
   input  logic                              i_addr_ready,
   output logic [DATA_DEPTH-1:0]             o_nbytes_bits,
   output logic                              o_nbytes_valid,
   input  logic                              i_nbytes_ready,
   output logic [DATA_DEPTH-1:0]             o_data_write_bits,
   output logic                              o_data_write_valid,
   input  logic                              i_data_write_ready,
   input  logic [DATA_DEPTH-1:0]             i_data_read_bits,
   input  logic                              i_data_read_valid,
   output logic                              o_data_read_ready,
   input  logic                              i_nak
);

   localparam int IDX_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
   localparam int ATT_W = $clog2(MAX_RETRIES + 2);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [DATA_DEPTH-1:0] WBUF_MAX = DATA_DEPTH'(WBUF_DEPTH);
   localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [ATT_W-1:0]      ATT_MAX  = ATT_W'(MAX_RETRIES);

   state_t                state;
   logic [6:0]            addr_q;
   logic                  rnw_q;
   logic [DATA_DEPTH-1:0] nbytes_q;
   logic [DATA_DEPTH-1:0] cnt;
   logic [ATT_W-1:0]      att;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  ok;
   logic                  done_q;
   logic                  err_q;
   logic [ATT_W-1:0]      attempts_q;

   logic                  last_byte;
   logic                  can_retry;
   logic                  rd_phase;
   logic [DATA_DEPTH-1:0] wbuf_rdata;

   assign last_byte = (cnt == (nbytes_q - DATA_DEPTH'(1)));
   assign can_retry = (att <= ATT_MAX);
   assign rd_phase  = (state == S_RDATA);

   i2c_wbuf #(
      .DATA_DEPTH (DATA_DEPTH),
      .WBUF_DEPTH (WBUF_DEPTH),
      .IDX_W      (IDX_W)
   ) u_wbuf (
      .i_clk   (i_clk),
      .i_we    ((state == S_LOAD) && i_wdata_valid),
      .i_waddr (cnt[IDX_W-1:0]),
      .i_wdata (i_wdata_bits),
      .i_raddr (cnt[IDX_W-1:0]),
      .o_rdata (wbuf_rdata)
   );

   // Handshake flags are decoded from the state register; payloads are
   // zeroed outside their phase so every output idles at its reset value.
   assign o_cmd_ready        = (state == S_IDLE);
   assign o_wdata_ready      = (state == S_LOAD);
   assign o_start            = (state == S_START);
   assign o_addr_valid       = (state == S_ADDR);
   assign o_addr_bits        = o_addr_valid ? DATA_DEPTH'(addr_byte(addr_q, rnw_q)) : '0;
   assign o_nbytes_valid     = (state == S_NBYTES);
   assign o_nbytes_bits      = o_nbytes_valid ? nbytes_q : '0;
   assign o_data_write_valid = (state == S_WDATA);
   assign o_data_write_bits  = o_data_write_valid ? wbuf_rdata : '0;

   // Read bytes pass straight through; a NAK in the same cycle suppresses
   // the byte so the user never sees data the master is abandoning.
   assign o_data_read_ready  = rd_phase && i_rdata_ready;
   assign o_rdata_valid      = rd_phase && i_data_read_valid && !i_nak;
   assign o_rdata_bits       = rd_phase ? i_data_read_bits : '0;
   assign o_rdata_last       = rd_phase && last_byte;

   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_attempts = attempts_q;

   // Transaction sequencer: descriptor intake, buffer load, master phases,
   // inter-attempt gap and status pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         rnw_q      <= 1'b0;
         nbytes_q   <= '0;
         cnt        <= '0;
         att        <= '0;
         gap_cnt    <= '0;
         ok         <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         attempts_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  addr_q   <= i_cmd_addr;
                  rnw_q    <= i_cmd_rnw;
                  nbytes_q <= i_cmd_nbytes;
                  att      <= ATT_W'(1);
                  cnt      <= '0;
                  ok       <= 1'b0;
                  if ((i_cmd_nbytes == '0) || (!i_cmd_rnw && (i_cmd_nbytes > WBUF_MAX))) begin
                     state      <= S_FAIL;
                     err_q      <= 1'b1;
                     attempts_q <= ATT_W'(1);
                  end else if (i_cmd_rnw) begin
                     state <= S_START;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (i_wdata_valid) begin
                  cnt <= cnt + DATA_DEPTH'(1);
                  if (last_byte) begin
                     state <= S_START;
                  end
               end
            end
            S_START: begin
               cnt   <= '0;
               state <= S_ADDR;
            end
            S_ADDR: begin
               if (i_nak) begin
                  gap_cnt <= '0;
                  if (can_retry) begin
                     state <= S_GAP;
                  end else begin
                     state      <= S_FAIL;
                     err_q      <= 1'b1;
                     attempts_q <= att;
                  end
               end else if (i_addr_ready) begin
                  state <= rnw_q ? S_NBYTES : S_WDATA;
               end
            end
            S_NBYTES: begin
               if (i_nak) begin
                  gap_cnt <= '0;
                  if (can_retry) begin
                     state <= S_GAP;
                  end else begin
                     state      <= S_FAIL;
                     err_q      <= 1'b1;
                     attempts_q <= att;
                  end
               end else if (i_nbytes_ready) begin
                  state <= S_RDATA;
               end
            end
            S_WDATA: begin
               if (i_nak) begin
                  gap_cnt <= '0;
                  if (can_retry) begin
                     state <= S_GAP;
                  end else begin
                     state      <= S_FAIL;
                     err_q      <= 1'b1;
                     attempts_q <= att;
                  end
               end else if (i_data_write_ready) begin
                  cnt <= cnt + DATA_DEPTH'(1);
                  if (last_byte) begin
                     ok      <= 1'b1;
                     gap_cnt <= '0;
                     state   <= S_GAP;
                  end
               end
            end
            S_RDATA: begin
               // Once a byte has reached the user a retry would duplicate it.
               if (i_nak) begin
                  gap_cnt <= '0;
                  if ((cnt == '0) && can_retry) begin
                     state <= S_GAP;
                  end else begin
                     state      <= S_FAIL;
                     err_q      <= 1'b1;
                     attempts_q <= att;
                  end
               end else if (i_data_read_valid && i_rdata_ready) begin
                  cnt <= cnt + DATA_DEPTH'(1);
                  if (last_byte) begin
                     ok      <= 1'b1;
                     gap_cnt <= '0;
                     state   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (ok) begin
                     done_q     <= 1'b1;
                     attempts_q <= att;
                     state      <= S_IDLE;
                  end else begin
                     att   <= att + ATT_W'(1);
                     state <= S_START;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_FAIL: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Directed bench for i2c_seq_ctrl: a small behavioural slave answers the
// master ports, a negedge monitor logs every handshake, and each scenario
// compares the log against hand-computed values.
module tb_i2c_seq_ctrl;
   import i2c_pkg::*;

   localparam int DW  = 8;
   localparam int WB  = 8;
   localparam int MR  = 2;
   localparam int GAP = 16;

   typedef logic [7:0] bytes_t [8];

   logic          clk = 1'b0;
   logic          i_rst;
   logic          i_cmd_valid, o_cmd_ready;
   logic [6:0]    i_cmd_addr;
   logic          i_cmd_rnw;
   logic [DW-1:0] i_cmd_nbytes;
   logic [DW-1:0] i_wdata_bits;
   logic          i_wdata_valid, o_wdata_ready;
   logic [DW-1:0] o_rdata_bits;
   logic          o_rdata_valid, i_rdata_ready, o_rdata_last;
   logic          o_done, o_err;
   logic [1:0]    o_attempts;
   logic          o_start;
   logic [DW-1:0] o_addr_bits;
   logic          o_addr_valid, i_addr_ready;
   logic [DW-1:0] o_nbytes_bits;
   logic          o_nbytes_valid, i_nbytes_ready;
   logic [DW-1:0] o_data_write_bits;
   logic          o_data_write_valid, i_data_write_ready;
   logic [DW-1:0] i_data_read_bits;
   logic          i_data_read_valid, o_data_read_ready;
   logic          i_nak;

   always #5 clk = ~clk;

   i2c_seq_ctrl #(
      .DATA_DEPTH  (DW),
      .WBUF_DEPTH  (WB),
      .MAX_RETRIES (MR),
      .GAP_CYCLES  (GAP)
   ) dut (
      .i_clk              (clk),
      .i_rst              (i_rst),
      .i_cmd_valid        (i_cmd_valid),
      .o_cmd_ready        (o_cmd_ready),
      .i_cmd_addr         (i_cmd_addr),
      .i_cmd_rnw          (i_cmd_rnw),
      .i_cmd_nbytes       (i_cmd_nbytes),
      .i_wdata_bits       (i_wdata_bits),
      .i_wdata_valid      (i_wdata_valid),
      .o_wdata_ready      (o_wdata_ready),
      .o_rdata_bits       (o_rdata_bits),
      .o_rdata_valid      (o_rdata_valid),
      .i_rdata_ready      (i_rdata_ready),
      .o_rdata_last       (o_rdata_last),
      .o_done             (o_done),
      .o_err              (o_err),
      .o_attempts         (o_attempts),
      .o_start            (o_start),
      .o_addr_bits        (o_addr_bits),
      .o_addr_valid       (o_addr_valid),
      .i_addr_ready       (i_addr_ready),
      .o_nbytes_bits      (o_nbytes_bits),
      .o_nbytes_valid     (o_nbytes_valid),
      .i_nbytes_ready     (i_nbytes_ready),
      .o_data_write_bits  (o_data_write_bits),
      .o_data_write_valid (o_data_write_valid),
      .i_data_write_ready (i_data_write_ready),
      .i_data_read_bits   (i_data_read_bits),
      .i_data_read_valid  (i_data_read_valid),
      .o_data_read_ready  (o_data_read_ready),
      .i_nak              (i_nak)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor log
   int          cyc = 0;
   int          n_start, n_done, n_err;
   int          acc_cyc, start_cyc, done_cyc, err_cyc, last_xfer_cyc, last_nak_cyc;
   int          gap_hist [8];
   logic [7:0]  last_addr, last_nb;
   logic [7:0]  wq [$];
   logic [7:0]  rq [$];
   logic        rlast [$];
   int          rd_ptr;
   bytes_t      rd_bytes;
   int          nak_addr_n;
   bit          nak_rd1, nak_wd;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_start) begin
         n_start++;
         start_cyc = cyc;
         if (n_start < 8) gap_hist[n_start] = cyc - last_nak_cyc - 1;
      end
      if (o_done) begin n_done++; done_cyc = cyc; end
      if (o_err)  begin n_err++;  err_cyc  = cyc; end
      if ((o_addr_valid || o_data_write_valid) && i_nak) last_nak_cyc = cyc;
      if (o_addr_valid && i_addr_ready && !i_nak) last_addr = o_addr_bits;
      if (o_nbytes_valid && i_nbytes_ready && !i_nak) last_nb = o_nbytes_bits;
      if (o_data_write_valid && i_data_write_ready && !i_nak) begin
         wq.push_back(o_data_write_bits);
         last_xfer_cyc = cyc;
      end
      if (o_rdata_valid && i_rdata_ready) begin
         rq.push_back(o_rdata_bits);
         rlast.push_back(o_rdata_last);
         last_xfer_cyc = cyc;
         rd_ptr++;
      end
   end

   // behavioural slave: read data source and NAK injection
   always @(posedge clk) begin
      #1;
      i_data_read_bits = rd_bytes[rd_ptr[2:0]];
      i_nak = ((nak_addr_n > 0) && o_addr_valid && (n_start <= nak_addr_n))
           || (nak_rd1 && (rd_ptr == 1))
           || (nak_wd && o_data_write_valid && (n_start == 1) && (wq.size() == 1));
   end

   function automatic logic [10:0] out_flags();
      return {o_cmd_ready, o_wdata_ready, o_start, o_addr_valid, o_nbytes_valid,
              o_data_write_valid, o_rdata_valid, o_data_read_ready, o_rdata_last,
              o_done, o_err};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic begin_test();
      n_start = 0; n_done = 0; n_err = 0;
      acc_cyc = 0; start_cyc = 0; done_cyc = 0; err_cyc = 0;
      last_xfer_cyc = 0; last_nak_cyc = 0;
      for (int i = 0; i < 8; i++) gap_hist[i] = 0;
      last_addr = '0; last_nb = '0;
      wq.delete(); rq.delete(); rlast.delete();
      rd_ptr = 0;
   endtask

   task automatic send_cmd(input logic [6:0] a, input logic rnw, input logic [7:0] n);
      bit ok = 1'b0;
      i_cmd_addr = a; i_cmd_rnw = rnw; i_cmd_nbytes = n; i_cmd_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (o_cmd_ready) begin ok = 1'b1; acc_cyc = cyc; break; end
         @(posedge clk); #1;
      end
      check_eq("cmd_accept", 32'(ok), 32'd1);
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic send_wdata(input bytes_t b, input int n);
      for (int i = 0; i < n; i++) begin
         bit ok = 1'b0;
         i_wdata_bits = b[i]; i_wdata_valid = 1'b1;
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_wdata_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
         end
         if (!ok) check_eq("wdata_accept", 32'(ok), 32'd1);
         @(posedge clk); #1;
      end
      i_wdata_valid = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int d0 = n_done;
      int e0 = n_err;
      bit seen = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if ((n_done != d0) || (n_err != e0)) begin seen = 1'b1; break; end
      end
      check_eq({tag, "_end_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic check_q(input string tag, input logic [7:0] q [$], input bytes_t exp, input int n);
      check_eq({tag, "_len"}, 32'(q.size()), 32'(n));
      for (int i = 0; i < n; i++)
         check_eq($sformatf("%s_b%0d", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hEEEE, 32'(exp[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] lbits;
      i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_rnw = 1'b0; i_cmd_nbytes = '0;
      i_wdata_bits = '0; i_wdata_valid = 1'b0; i_rdata_ready = 1'b1;
      i_addr_ready = 1'b1; i_nbytes_ready = 1'b1; i_data_write_ready = 1'b1;
      i_data_read_valid = 1'b0; i_data_read_bits = '0; i_nak = 1'b0;
      nak_addr_n = 0; nak_rd1 = 1'b0; nak_wd = 1'b0;
      rd_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      begin_test();

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_flags", 32'(out_flags()), 32'h400);
      check_eq("rst_attempts", 32'(o_attempts), 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;
      idle(2);

      // read 0x50, 3 bytes
      begin_test();
      rd_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      i_data_read_valid = 1'b1;
      send_cmd(7'h50, 1'b1, 8'd3);
      wait_end("rd3");
      check_eq("rd3_addr", 32'(last_addr), 32'hA1);
      check_eq("rd3_nbytes", 32'(last_nb), 32'd3);
      check_eq("rd3_latency", 32'(start_cyc - acc_cyc), 32'd1);
      check_q("rd3_data", rq, rd_bytes, 3);
      lbits = '0;
      for (int i = 0; i < rlast.size() && i < 3; i++) lbits = {lbits[1:0], rlast[i]};
      check_eq("rd3_last", 32'(lbits), 32'b001);
      check_eq("rd3_done", 32'(n_done), 32'd1);
      check_eq("rd3_err", 32'(n_err), 32'd0);
      check_eq("rd3_attempts", 32'(o_attempts), 32'd1);
      check_eq("rd3_gap", 32'(done_cyc - last_xfer_cyc), 32'(GAP + 1));
      i_data_read_valid = 1'b0;
      idle(3);

      // write 0x3C: 0x00, 0xAF
      begin_test();
      send_cmd(7'h3C, 1'b0, 8'd2);
      send_wdata('{8'h00, 8'hAF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
      wait_end("wr2");
      check_eq("wr2_addr", 32'(last_addr), 32'h78);
      check_q("wr2_data", wq, '{8'h00, 8'hAF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
      check_eq("wr2_latency", 32'(start_cyc - acc_cyc), 32'd3);
      check_eq("wr2_gap", 32'(done_cyc - last_xfer_cyc), 32'(GAP + 1));
      check_eq("wr2_done", 32'(n_done), 32'd1);
      idle(3);

      // write with address NAK on attempts 1 and 2
      begin_test();
      nak_addr_n = 2;
      send_cmd(7'h10, 1'b0, 8'd2);
      send_wdata('{8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
      wait_end("retry");
      check_eq("retry_starts", 32'(n_start), 32'd3);
      check_eq("retry_gap2", 32'(gap_hist[2]), 32'(GAP));
      check_eq("retry_gap3", 32'(gap_hist[3]), 32'(GAP));
      check_eq("retry_addr", 32'(last_addr), 32'h20);
      check_q("retry_data", wq, '{8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
      check_eq("retry_done", 32'(n_done), 32'd1);
      check_eq("retry_attempts", 32'(o_attempts), 32'd3);
      nak_addr_n = 0;
      idle(3);

      // NAK on every attempt
      begin_test();
      nak_addr_n = 3;
      send_cmd(7'h22, 1'b1, 8'd1);
      wait_end("allnak");
      idle(30);
      check_eq("allnak_starts", 32'(n_start), 32'd3);
      check_eq("allnak_err", 32'(n_err), 32'd1);
      check_eq("allnak_done", 32'(n_done), 32'd0);
      check_eq("allnak_attempts", 32'(o_attempts), 32'd3);
      nak_addr_n = 0;
      idle(3);

      // nbytes = 0
      begin_test();
      send_cmd(7'h12, 1'b1, 8'd0);
      wait_end("zero");
      check_eq("zero_err_lat", 32'(err_cyc - acc_cyc), 32'd1);
      check_eq("zero_starts", 32'(n_start), 32'd0);
      check_eq("zero_attempts", 32'(o_attempts), 32'd1);
      idle(3);

      // write longer than buffer
      begin_test();
      send_cmd(7'h12, 1'b0, 8'd9);
      wait_end("big");
      idle(10);
      check_eq("big_err", 32'(n_err), 32'd1);
      check_eq("big_err_lat", 32'(err_cyc - acc_cyc), 32'd1);
      check_eq("big_starts", 32'(n_start), 32'd0);
      idle(3);

      // NAK mid-write: buffer replayed on the second attempt
      begin_test();
      nak_wd = 1'b1;
      send_cmd(7'h20, 1'b0, 8'd3);
      send_wdata('{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      wait_end("replay");
      check_q("replay_data", wq, '{8'h11, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
      check_eq("replay_gap2", 32'(gap_hist[2]), 32'(GAP));
      check_eq("replay_done", 32'(n_done), 32'd1);
      check_eq("replay_attempts", 32'(o_attempts), 32'd2);
      nak_wd = 1'b0;
      idle(3);

      // NAK during read after the first byte
      begin_test();
      rd_bytes = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      i_data_read_valid = 1'b1;
      nak_rd1 = 1'b1;
      send_cmd(7'h40, 1'b1, 8'd3);
      wait_end("rdnak");
      idle(30);
      check_q("rdnak_data", rq, rd_bytes, 1);
      check_eq("rdnak_err", 32'(n_err), 32'd1);
      check_eq("rdnak_done", 32'(n_done), 32'd0);
      check_eq("rdnak_starts", 32'(n_start), 32'd1);
      nak_rd1 = 1'b0;
      i_data_read_valid = 1'b0;
      idle(3);

      // reset during WDATA
      begin_test();
      begin
         bit seen = 1'b0;
         send_cmd(7'h33, 1'b0, 8'd4);
         send_wdata('{8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_data_write_valid) begin seen = 1'b1; break; end
         end
         check_eq("rstw_reached", 32'(seen), 32'd1);
         @(posedge clk); #1;
         i_rst = 1'b1;
         @(negedge clk);
         @(negedge clk);
         check_eq("rstw_flags", 32'(out_flags()), 32'h400);
         check_eq("rstw_buses", {o_addr_bits, o_nbytes_bits, o_data_write_bits, o_rdata_bits}, 32'd0);
         check_eq("rstw_attempts", 32'(o_attempts), 32'd0);
         @(posedge clk); #1;
         i_rst = 1'b0;
         idle(30);
         check_eq("rstw_no_end", 32'(n_done + n_err), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_seq_ctrl.md
# i2c_seq_ctrl

Parametrised transaction sequencer that replaces the fixed single-purpose I2C controller FSM. It accepts transaction descriptors and write bytes on stream inputs and drives the `i2c_master_oe` stream interface. It returns read bytes on an output stream and retries NAKed transactions from an internal write buffer. It sits between user logic and `i2c_master_oe` in the I2C top level.

## Interface
- `DATA_DEPTH`, 8: width of all byte/stream buses.
- `WBUF_DEPTH`, 8: write buffer depth in bytes; maximum write length.
- `MAX_RETRIES`, 2: extra attempts after a NAK before reporting an error.
- `GAP_CYCLES`, 16: idle cycles enforced after every transaction end and before every retry.
---
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_cmd_valid`/`o_cmd_ready` in/out 1: descriptor handshake.
- `i_cmd_addr` in 7: target address.
- `i_cmd_rnw` in 1: 1 = read, 0 = write.
- `i_cmd_nbytes` in DATA_DEPTH: byte count.
- `i_wdata_bits`/`i_wdata_valid`/`o_wdata_ready` in/in/out DATA_DEPTH/1/1: user write bytes.
- `o_rdata_bits`/`o_rdata_valid`/`i_rdata_ready`/`o_rdata_last` out/out/in/out DATA_DEPTH/1/1/1: read bytes to the user.
- `o_done` out 1: one-cycle success pulse.
- `o_err` out 1: one-cycle failure pulse.
- `o_attempts` out 2+: attempts used by the last transaction, width `$clog2(MAX_RETRIES+2)`.
- Master side: `o_start`, `o_addr_bits[DATA_DEPTH]`/`o_addr_valid`/`i_addr_ready`, `o_nbytes_bits[DATA_DEPTH]`/`o_nbytes_valid`/`i_nbytes_ready`, `o_data_write_bits[DATA_DEPTH]`/`o_data_write_valid`/`i_data_write_ready`, `i_data_read_bits[DATA_DEPTH]`/`i_data_read_valid`/`o_data_read_ready`, `i_nak`.

## Operation
- **Handshake rule.** A transfer occurs on a cycle with valid && ready. Every valid is held, with stable bits, until its transfer.
- **States:** IDLE, LOAD, START, ADDR, NBYTES, WDATA, RDATA, GAP, FAIL.
- **IDLE**
  - `o_cmd_ready`=1.
  - On a descriptor transfer, latch addr, rnw and nbytes, and clear the attempt counter to 1.
  - nbytes=0, or a write with nbytes>WBUF_DEPTH, goes to FAIL.
  - Otherwise a write goes to LOAD and a read goes to START.
- **LOAD**
  - `o_wdata_ready`=1.
  - Store bytes into the buffer at index 0..nbytes-1.
  - After the nbytes-th byte, go to START.
- **START.** Drive `o_start`=1 for exactly one cycle, then go to ADDR.
- **ADDR**
  - `o_addr_bits` = {addr, rnw}; the R/W bit is the LSB.
  - On transfer, a read goes to NBYTES and a write goes to WDATA with the buffer read index cleared.
- **NBYTES.** Present nbytes; on transfer go to RDATA.
- **WDATA**
  - Present `buf[idx]` and increment idx on each transfer.
  - After the transfer of the last byte, drop valid, set the success flag and go to GAP.
- **RDATA**
  - `o_data_read_ready` = `i_rdata_ready` (combinational pass-through).
  - `o_rdata_valid` = `i_data_read_valid`.
  - `o_rdata_last` is 1 on the nbytes-th byte.
  - After that byte transfers, set the success flag and go to GAP.
- **GAP**
  - Count GAP_CYCLES.
  - On expiry: if the success flag is set, pulse `o_done` and go to IDLE.
  - If a retry is pending, increment attempts and go to START. The buffer contents are preserved, so the write is replayed.
- **NAK handling.** `i_nak` is sampled in ADDR, NBYTES and WDATA, and in RDATA only before the first read byte is forwarded.
  - If attempts ≤ MAX_RETRIES, go to GAP with a retry pending.
  - Otherwise go to FAIL.
  - A NAK in RDATA after any forwarded byte goes straight to FAIL; no retry, because the data is already delivered.
- **FAIL.** Pulse `o_err` for one cycle, go to IDLE. Any remaining user read stream is not completed.
- **Attempts output.** `o_attempts` updates when `o_done` or `o_err` pulses.

## Timing
- **Reset.** All outputs are 0 except `o_cmd_ready`=1. State returns to IDLE. `i_rst` mid-transaction aborts immediately, with no `o_done`/`o_err`; buffer contents are don't-care.
- **Latency.** Descriptor transfer to `o_start`:
  - Read: 1 cycle.
  - Write: nbytes + 1 cycles with `i_wdata_valid` held high.
- **Gap.** Last data transfer to `o_done` is GAP_CYCLES + 1 cycles.
- **Simultaneous events.** When `i_nak` coincides with a data transfer in the same cycle, the NAK wins: the byte is discarded and the retry/fail path is taken.
- **Buffer index.** Width `$clog2(WBUF_DEPTH)`, no wrap. The index is compared against nbytes-1.

## Structure
- Shared package `i2c_pkg`: the state enum encoding, and the R/W bit position constant (LSB).
- Sub-module `i2c_wbuf`: a simple dual-index register array of WBUF_DEPTH×DATA_DEPTH. It has a write port (LOAD) and a read port (WDATA), with no full/empty logic because the sequencer tracks the counts.
- The existing FSM+I2C top swaps its FSM for this block; the master port names match `i2c_master_oe` one to one.

## Test plan
- Read addr 0x50, nbytes 3, slave returns 0xA1, 0xB2, 0xC3.
  - Expect `o_addr_bits`=0xA1 and `o_nbytes_bits`=3.
  - User stream delivers the three bytes, with last on 0xC3.
  - One `o_done`, `o_attempts`=1.
- Write addr 0x3C with bytes 0x00, 0xAF.
  - Expect `o_addr_bits`=0x78 and the write stream 0x00, 0xAF.
  - `o_done` arrives GAP_CYCLES+1 after the last transfer.
- Write with a NAK on the address phase of attempts 1 and 2, ACK on 3.
  - Each attempt presents identical bytes, with exactly GAP_CYCLES idle cycles before each `o_start`.
  - `o_done` with `o_attempts`=3.
- NAK on every attempt with MAX_RETRIES=2: three `o_start` pulses, then one `o_err`, no `o_done`.
- Descriptor errors:
  - nbytes=0 gives `o_err` 1 cycle after acceptance.
  - A write with nbytes=9 (WBUF_DEPTH=8) gives `o_err` and no `o_start`.
- Other cases:
  - `i_rst` asserted during WDATA: all outputs return to reset values the next cycle.
  - NAK during RDATA after byte 1: `o_err`, no retry.
